scr_arbiter: RTL and testbench
==============================

Name: scr_arbiter

Overview:
- Two-port arbiter that shares the single-port scratch RAM (256 x 10-bit, combinational read, write on CLK rising edge) between two requesters.
  - Port A: CPU (LD/ST/PUSH/POP).
  - Port B: DMA/debug loader.
- Sits between both requesters and the scratch RAM, and drives its DATA_IN, SCR_ADDR and SCR_WE.
- Port A has fixed priority, with a starvation guard for B and an optional B lock for atomic read-modify-write.

Parameters:
- MAX_WAIT, 4: consecutive cycles B may be refused while requesting before it gets a forced grant (range 1..15).
- MAX_LOCK, 8: maximum consecutive locked B grants (range 1..15).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- A_REQ  in  1  CPU access request
- A_WE  in  1  CPU write (1) / read (0)
- A_ADDR  in  8  CPU address
- A_WDATA  in  10  CPU write data
- A_GNT  out  1  CPU granted this cycle (combinational)
- A_RDATA  out  10  CPU read data (registered)
- A_RVALID  out  1  A_RDATA valid pulse
- B_REQ, B_WE, B_ADDR[8], B_WDATA[10], B_GNT, B_RDATA[10], B_RVALID: same meanings for port B
- B_LOCK  in  1  B requests to keep ownership on following cycles
- SCR_ADDR  out  8  to RAM
- SCR_WE  out  1  to RAM
- SCR_DIN  out  10  to RAM DATA_IN
- SCR_DOUT  in  10  from RAM DATA_OUT

Behaviour:
- Reset is asynchronous and active-low on RST_N; clock is CLK. While RST_N=0:
  - state=ARB, starve_cnt=0, lock_cnt=0.
  - A_RVALID=B_RVALID=0, A_RDATA=B_RDATA=0.
  - A_GNT=B_GNT=0, SCR_WE=0.
- At most one grant per cycle. Grant is combinational from the current REQs and registered state.
- Winner's ADDR/WDATA/WE are muxed onto the SCR_* outputs.
  - No grant: SCR_WE=0, SCR_ADDR=0, SCR_DIN=0.
- Read: granted with WE=0 in cycle N gives RDATA<=SCR_DOUT at the edge ending N, and RVALID=1 for cycle N+1 only. RDATA holds until the next read.
- Write: commits at the edge ending the grant cycle. There is no RVALID.
- Grant-cycle reads see the pre-write RAM content.
- State ARB:
  - Only A_REQ: grant A.
  - Only B_REQ: grant B; starve_cnt<=0.
  - Both, and starve_cnt<MAX_WAIT: grant A; starve_cnt<=starve_cnt+1.
  - Both, and starve_cnt==MAX_WAIT: grant B (forced); starve_cnt<=0.
  - B granted with B_LOCK=1: go to LOCK, lock_cnt<=1.
  - Neither requesting: starve_cnt unchanged.
- State LOCK:
  - B_REQ&B_LOCK and lock_cnt<MAX_LOCK: grant B regardless of A_REQ; lock_cnt++.
  - Otherwise return to ARB with lock_cnt<=0, and arbitrate that same cycle with ARB rules.
  - Fairness on exit: starve_cnt<=0, so A wins the next contended cycle.
- Requesters hold REQ/ADDR/WDATA/WE stable until GNT is seen. Dropping REQ without a grant is legal and has no side effects.
- Same address from both ports in one cycle: only the winner accesses. No merging.
- Reset asserted mid-read: the pending RVALID is lost. No RAM write occurs once RST_N=0.

Optional Feature:
- Macro SCR_ARB_STATS_EN.
- When defined:
  - Extra output CONFLICT_CNT[15:0]: increments on every cycle where A_REQ&B_REQ and only one is granted. Saturates at 16'hFFFF. Reset to 0.
  - Extra input STATS_CLR (1): synchronous clear; wins over an increment in the same cycle.
- When undefined: neither port exists, and there is no counter logic.

Decomposition:
- Package scr_pkg:
  - SCR_AW=8, SCR_DW=10.
  - typedef enum logic {ARB, LOCK} arb_state_t.
  - typedef struct {we, addr, wdata} scr_req_t.
- One natural sub-module: scr_rd_capture. It holds the per-port registered RDATA/RVALID and is instantiated twice.

Test Plan:
- Reset, then A write 0x2A5 @ addr 0x10, then A read 0x10 -> A_GNT=1 both cycles; A_RVALID=1 one cycle later with A_RDATA=0x2A5.
- A_REQ and B_REQ held continuously, MAX_WAIT=4 -> grant pattern A,A,A,A,B,A,A,A,A,B; B_GNT exactly every 5th cycle.
- B write 0x3FF @ 0xFF with B_LOCK=1 for 3 cycles while A_REQ=1 -> B_GNT for 3 consecutive cycles, A_GNT=0; A granted on the 4th cycle.
- B_LOCK held 12 cycles, MAX_LOCK=8, A_REQ=1 -> lock releases after 8 B grants; next cycle A_GNT=1.
- RST_N pulled low mid B read (cycle N) -> B_RVALID stays 0; SCR_WE=0; all counters 0 after release.
- (SCR_ARB_STATS_EN) 10 contended cycles, then STATS_CLR -> CONFLICT_CNT=10, then 0. Preload 0xFFFF plus contention -> stays 0xFFFF.

Source files
------------

// File: rtl/scr_arbiter_pkg.sv
// Shared types and widths for the scratch-RAM arbiter.
// Optional conflict statistics are enabled with the SCR_ARB_STATS_EN macro.
package scr_pkg;

  localparam int SCR_AW = 8;
  localparam int SCR_DW = 10;
  localparam int CNT_W  = 4;
  localparam int STAT_W = 16;

  typedef enum logic {
    ARB,
    LOCK
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [SCR_AW-1:0] addr;
    logic [SCR_DW-1:0] wdata;
  } scr_req_t;

  // MAX_WAIT / MAX_LOCK are limited to 1..15, so they fit the 4-bit counters.
  function automatic logic [CNT_W-1:0] to_cnt(input int v);
    return CNT_W'(v);
  endfunction

endpackage

// File: rtl/scr_arbiter_if.sv
// One requester port of the scratch-RAM arbiter (request, grant, read return).
// The requester drives the master side; the arbiter uses the slave side.
interface scr_arbiter_if;
  import scr_pkg::*;

  logic              req;
  logic              we;
  logic              lock;
  logic [SCR_AW-1:0] addr;
  logic [SCR_DW-1:0] wdata;
  logic              gnt;
  logic [SCR_DW-1:0] rdata;
  logic              rvalid;

  modport master (
    output req, we, lock, addr, wdata,
    input  gnt, rdata, rvalid
  );

  modport slave (
    input  req, we, lock, addr, wdata,
    output gnt, rdata, rvalid
  );

endinterface

// File: rtl/scr_arbiter_rd_capture.sv
// Per-port read return: latches RAM data at the end of a granted read cycle and
// raises a one-cycle valid pulse; data holds until the next read.
module scr_rd_capture
  import scr_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cap,
  input  logic [SCR_DW-1:0] i_din,
  output logic [SCR_DW-1:0] o_rdata,
  output logic              o_rvalid
);

  logic [SCR_DW-1:0] r_rdata;
  logic              r_rvalid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= i_cap;
      if (i_cap) begin
        r_rdata <= i_din;
      end
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;

endmodule

// File: rtl/scr_arbiter.sv
// Two-port arbiter for the single-port scratch RAM: CPU (A) has fixed priority,
// DMA (B) gets a starvation guard and optional locked bursts. Macro: SCR_ARB_STATS_EN.
module scr_arbiter
  import scr_pkg::*;
#(
  parameter int MAX_WAIT = 4,
  parameter int MAX_LOCK = 8
)
(
  input  logic              CLK,
  input  logic              RST_N,
  scr_arbiter_if.slave      a_port,
  scr_arbiter_if.slave      b_port,
  output logic [SCR_AW-1:0] SCR_ADDR,
  output logic              SCR_WE,
  output logic [SCR_DW-1:0] SCR_DIN,
  input  logic [SCR_DW-1:0] SCR_DOUT
`ifdef SCR_ARB_STATS_EN
  ,
  input  logic              STATS_CLR,
  output logic [STAT_W-1:0] CONFLICT_CNT
`endif
);

  localparam logic [CNT_W-1:0] L_MAX_WAIT = to_cnt(MAX_WAIT);
  localparam logic [CNT_W-1:0] L_MAX_LOCK = to_cnt(MAX_LOCK);
  localparam logic [CNT_W-1:0] L_ONE      = to_cnt(1);

  arb_state_t       r_state;
  arb_state_t       w_state_next;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_starve_next;
  logic [CNT_W-1:0] w_starve_eff;
  logic [CNT_W-1:0] r_lock_cnt;
  logic [CNT_W-1:0] w_lock_next;
  logic             w_arb_en;
  logic             w_gnt_a;
  logic             w_gnt_b;

  scr_req_t w_req_a;
  scr_req_t w_req_b;
  scr_req_t w_sel;

  logic w_unused_a_lock;
  assign w_unused_a_lock = a_port.lock;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= ARB;
      r_starve_cnt <= '0;
      r_lock_cnt   <= '0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_starve_next;
      r_lock_cnt   <= w_lock_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_starve_next = r_starve_cnt;
    w_starve_eff  = r_starve_cnt;
    w_lock_next   = r_lock_cnt;
    w_arb_en      = 1'b1;
    w_gnt_a       = 1'b0;
    w_gnt_b       = 1'b0;

    if (r_state == LOCK) begin
      if (b_port.req && b_port.lock && (r_lock_cnt < L_MAX_LOCK)) begin
        w_gnt_b     = 1'b1;
        w_lock_next = r_lock_cnt + L_ONE;
        w_arb_en    = 1'b0;
      end else begin
        // Leaving a lock clears the wait count so A wins the next contention.
        w_state_next  = ARB;
        w_lock_next   = '0;
        w_starve_eff  = '0;
        w_starve_next = '0;
      end
    end

    if (w_arb_en) begin
      if (a_port.req && !b_port.req) begin
        w_gnt_a = 1'b1;
      end else if (!a_port.req && b_port.req) begin
        w_gnt_b       = 1'b1;
        w_starve_next = '0;
      end else if (a_port.req && b_port.req) begin
        if (w_starve_eff < L_MAX_WAIT) begin
          w_gnt_a       = 1'b1;
          w_starve_next = w_starve_eff + L_ONE;
        end else begin
          w_gnt_b       = 1'b1;
          w_starve_next = '0;
        end
      end
      if (w_gnt_b && b_port.lock) begin
        w_state_next = LOCK;
        w_lock_next  = L_ONE;
      end
    end

    // Grants are combinational, so they must be masked while reset is held.
    if (!RST_N) begin
      w_gnt_a = 1'b0;
      w_gnt_b = 1'b0;
    end
  end

  assign w_req_a = '{we: a_port.we, addr: a_port.addr, wdata: a_port.wdata};
  assign w_req_b = '{we: b_port.we, addr: b_port.addr, wdata: b_port.wdata};

  always_comb begin
    w_sel = '0;
    if (w_gnt_a) begin
      w_sel = w_req_a;
    end else if (w_gnt_b) begin
      w_sel = w_req_b;
    end
  end

  assign SCR_WE   = w_sel.we;
  assign SCR_ADDR = w_sel.addr;
  assign SCR_DIN  = w_sel.wdata;

  assign a_port.gnt = w_gnt_a;
  assign b_port.gnt = w_gnt_b;

  scr_rd_capture u_rd_a (
    .i_clk    (CLK),
    .i_rst_n  (RST_N),
    .i_cap    (w_gnt_a & ~a_port.we),
    .i_din    (SCR_DOUT),
    .o_rdata  (a_port.rdata),
    .o_rvalid (a_port.rvalid)
  );

  scr_rd_capture u_rd_b (
    .i_clk    (CLK),
    .i_rst_n  (RST_N),
    .i_cap    (w_gnt_b & ~b_port.we),
    .i_din    (SCR_DOUT),
    .o_rdata  (b_port.rdata),
    .o_rvalid (b_port.rvalid)
  );

`ifdef SCR_ARB_STATS_EN
  logic [STAT_W-1:0] r_conflict_cnt;
  logic              w_conflict;

  assign w_conflict = a_port.req & b_port.req & (w_gnt_a ^ w_gnt_b);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_conflict_cnt <= '0;
    end else if (STATS_CLR) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != {STAT_W{1'b1}})) begin
      r_conflict_cnt <= r_conflict_cnt + STAT_W'(1);
    end
  end

  assign CONFLICT_CNT = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_scr_arbiter.sv
// Scoreboard bench for scr_arbiter: a stimulus thread runs a rule-level model
// and queues per-cycle expectations; a monitor thread compares on each falling edge.
module tb_scr_arbiter;

  localparam int MAX_WAIT = 4;
  localparam int MAX_LOCK = 8;

  typedef struct {
    bit         ga;
    bit         gb;
    bit         we;
    logic [7:0] addr;
    logic [9:0] din;
    bit         rva;
    logic [9:0] rda;
    bit         rvb;
    logic [9:0] rdb;
    logic [15:0] conf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] scr_addr;
  logic       scr_we;
  logic [9:0] scr_din;
  logic [9:0] scr_dout;
  logic       stats_clr = 1'b0;
`ifdef SCR_ARB_STATS_EN
  logic [15:0] conflict_cnt;
`endif

  scr_arbiter_if a_if ();
  scr_arbiter_if b_if ();

  scr_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .a_port   (a_if),
    .b_port   (b_if),
    .SCR_ADDR (scr_addr),
    .SCR_WE   (scr_we),
    .SCR_DIN  (scr_din),
    .SCR_DOUT (scr_dout)
`ifdef SCR_ARB_STATS_EN
    ,
    .STATS_CLR    (stats_clr),
    .CONFLICT_CNT (conflict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Scratch RAM: combinational read, write on rising edge.
  logic [9:0] ram [256] = '{default: 10'h0};
  assign scr_dout = ram[scr_addr];
  always @(posedge clk) if (scr_we) ram[scr_addr] <= scr_din;

  // Stimulus values and reference-model state.
  bit         a_req, a_we, b_req, b_we, b_lock;
  logic [7:0] a_addr, b_addr;
  logic [9:0] a_wdata, b_wdata;
  bit         g_a, g_b;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  exp_t       exp_q [$];

  logic [9:0] m_mem [256] = '{default: 10'h0};
  int         m_refused = 0;
  int         m_locked = 0;
  bit         m_rva, m_rvb;
  logic [9:0] m_rda = 10'h0, m_rdb = 10'h0;
  logic [15:0] m_conf = 16'h0;

  task automatic set_a(input bit req, input bit we, input logic [7:0] addr, input logic [9:0] wd);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd;
  endtask

  task automatic set_b(input bit req, input bit we, input bit lk, input logic [7:0] addr,
                       input logic [9:0] wd);
    b_req = req; b_we = we; b_lock = lk; b_addr = addr; b_wdata = wd;
  endtask

  // One clock cycle: drive inputs, predict this cycle's outputs, then advance the model.
  task automatic step(input bit rst_v);
    exp_t e;
    int   w;
    @(posedge clk);
    #1;
    rst_n = rst_v;
    a_if.req = a_req; a_if.we = a_we; a_if.lock = 1'b0; a_if.addr = a_addr; a_if.wdata = a_wdata;
    b_if.req = b_req; b_if.we = b_we; b_if.lock = b_lock; b_if.addr = b_addr; b_if.wdata = b_wdata;
    cyc++;
    w = 0;
    e.ga = 0; e.gb = 0; e.we = 0; e.addr = 8'h0; e.din = 10'h0;
    if (!rst_v) begin
      m_refused = 0; m_locked = 0; m_rva = 0; m_rvb = 0;
      m_rda = 10'h0; m_rdb = 10'h0; m_conf = 16'h0;
      e.rva = 0; e.rda = 10'h0; e.rvb = 0; e.rdb = 10'h0; e.conf = 16'h0;
    end else begin
      e.rva = m_rva; e.rda = m_rda; e.rvb = m_rvb; e.rdb = m_rdb; e.conf = m_conf;
      if (m_locked > 0) begin
        if (b_req && b_lock && m_locked < MAX_LOCK) begin
          w = 2;
          m_locked++;
        end else begin
          m_locked = 0;
          m_refused = 0;
        end
      end
      if (w == 0) begin
        if (a_req && !b_req) w = 1;
        else if (b_req && !a_req) begin w = 2; m_refused = 0; end
        else if (a_req && b_req) begin
          if (m_refused < MAX_WAIT) begin w = 1; m_refused++; end
          else begin w = 2; m_refused = 0; end
        end
        if (w == 2 && b_lock) m_locked = 1;
      end
      if (w == 1) begin e.ga = 1; e.we = a_we; e.addr = a_addr; e.din = a_wdata; end
      if (w == 2) begin e.gb = 1; e.we = b_we; e.addr = b_addr; e.din = b_wdata; end
      m_rva = (w == 1) && !a_we;
      m_rvb = (w == 2) && !b_we;
      if (m_rva) m_rda = m_mem[a_addr];
      if (m_rvb) m_rdb = m_mem[b_addr];
      if (w != 0 && e.we) m_mem[e.addr] = e.din;
      if (stats_clr) m_conf = 16'h0;
      else if (a_req && b_req && w != 0 && m_conf != 16'hFFFF) m_conf = m_conf + 16'h1;
    end
    g_a = e.ga;
    g_b = e.gb;
    exp_q.push_back(e);
  endtask

  // Monitor: pops one expectation per cycle and compares on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (a_if.gnt || b_if.gnt)
          $display("cyc=%0d %s %s addr=%02h din=%03h", cyc, a_if.gnt ? "A" : "B",
                   scr_we ? "WR" : "RD", scr_addr, scr_din);
        n_chk++;
        if ({a_if.gnt, b_if.gnt, scr_we, scr_addr, scr_din} === {e.ga, e.gb, e.we, e.addr, e.din})
          n_pass++;
        else
          $display("FAIL bus cyc=%0d got gA=%0b gB=%0b we=%0b addr=%02h din=%03h exp gA=%0b gB=%0b we=%0b addr=%02h din=%03h",
                   cyc, a_if.gnt, b_if.gnt, scr_we, scr_addr, scr_din, e.ga, e.gb, e.we, e.addr, e.din);
        n_chk++;
        if ({a_if.rvalid, a_if.rdata} === {e.rva, e.rda}) n_pass++;
        else $display("FAIL rd_a cyc=%0d got v=%0b d=%03h exp v=%0b d=%03h",
                      cyc, a_if.rvalid, a_if.rdata, e.rva, e.rda);
        n_chk++;
        if ({b_if.rvalid, b_if.rdata} === {e.rvb, e.rdb}) n_pass++;
        else $display("FAIL rd_b cyc=%0d got v=%0b d=%03h exp v=%0b d=%03h",
                      cyc, b_if.rvalid, b_if.rdata, e.rvb, e.rdb);
`ifdef SCR_ARB_STATS_EN
        n_chk++;
        if (conflict_cnt === e.conf) n_pass++;
        else $display("FAIL conflict cyc=%0d got %04h exp %04h", cyc, conflict_cnt, e.conf);
`endif
      end
    end
  end

  initial begin
    bit a_pend = 0, b_pend = 0;
    int lock_left = 0;
    bit rst_v;

    set_a(0, 0, 8'h00, 10'h000);
    set_b(0, 0, 0, 8'h00, 10'h000);
    repeat (3) step(1'b0);

    // A write then A read back.
    set_a(1, 1, 8'h10, 10'h2A5); step(1'b1);
    set_a(1, 0, 8'h10, 10'h000); step(1'b1);
    set_a(0, 0, 8'h00, 10'h000); step(1'b1);

    // Continuous contention: B forced in every MAX_WAIT+1 cycles.
    set_a(1, 0, 8'h10, 10'h000);
    set_b(1, 0, 0, 8'h11, 10'h000);
    repeat (10) step(1'b1);
    set_a(0, 0, 8'h00, 10'h000);
    set_b(0, 0, 0, 8'h00, 10'h000);
    step(1'b1);

    // Short locked burst against a waiting A.
    set_b(1, 1, 1, 8'hFF, 10'h3FF); step(1'b1);
    set_a(1, 0, 8'hFF, 10'h000);    step(1'b1);
    step(1'b1);
    set_b(0, 0, 0, 8'h00, 10'h000); step(1'b1);
    set_a(0, 0, 8'h00, 10'h000);    step(1'b1);

    // Lock held past MAX_LOCK.
    set_b(1, 0, 1, 8'hFF, 10'h000); step(1'b1);
    set_a(1, 1, 8'h20, 10'h155);
    repeat (11) step(1'b1);
    set_a(0, 0, 8'h00, 10'h000);
    set_b(0, 0, 0, 8'h00, 10'h000);
    repeat (6) step(1'b1);

    // Reset during a pending B read and during a B write request.
    set_b(1, 0, 0, 8'h10, 10'h000); step(1'b1);
    set_b(1, 1, 0, 8'h10, 10'h111); step(1'b0);
    step(1'b0);
    set_b(1, 0, 0, 8'h10, 10'h000); step(1'b1);
    set_b(0, 0, 0, 8'h00, 10'h000); step(1'b1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      if (!a_pend && ($urandom % 4) != 0) begin
        a_pend = 1; a_we = 1'($urandom % 2); a_addr = 8'($urandom % 16); a_wdata = 10'($urandom);
      end else if (a_pend && ($urandom % 25) == 0) begin
        a_pend = 0;
      end
      if (lock_left == 0 && !b_pend && ($urandom % 10) == 0) lock_left = $urandom_range(1, 12);
      if (!b_pend && (lock_left > 0 || ($urandom % 3) == 0)) begin
        b_pend = 1; b_we = 1'($urandom % 2); b_addr = 8'($urandom % 16); b_wdata = 10'($urandom);
      end
      a_req = a_pend;
      b_req = b_pend;
      b_lock = (lock_left > 0);
      stats_clr = (($urandom % 50) == 0);
      rst_v = (($urandom % 250) != 0);
      step(rst_v);
      if (g_a) a_pend = 0;
      if (g_b) begin
        b_pend = 0;
        if (lock_left > 0) lock_left--;
      end
    end

    stats_clr = 0;
    set_a(0, 0, 8'h00, 10'h000);
    set_b(0, 0, 0, 8'h00, 10'h000);
    repeat (2) step(1'b1);
    repeat (3) @(negedge clk);
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain got %0d pending exp 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
